// File: rtl/mhsa_connect_gather_pkg.sv
// Shared constants and types for the head-concatenation (connect) mover.
package mhsa_pkg;

    // Datapath and problem geometry
    localparam int DATA_W     = 64;
    localparam int WIDTH      = DATA_W;
    localparam int ADDR_W     = 32;
    localparam int N_HEAD     = 4;
    localparam int SEQ_LEN    = 32;
    localparam int WPR        = 4;
    localparam int FIFO_DEPTH = 4;

    // Words moved per transfer
    localparam int TOTAL = N_HEAD * SEQ_LEN * WPR;

    // Bank base word addresses
    localparam int ATTMM_OUTPUT_BASE   = 2560;
    localparam int CONNECT_OUTPUT_BASE = 3072;

    // Mover control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mhsa_connect_gather_fifo.sv
// Small synchronous FIFO holding {dst_addr, data} return entries.
// The head entry is presented combinationally; DEPTH must be a power of 2.
module mhsa_sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_data    = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mhsa_connect_gather.sv
// Head-concatenation mover: reads attmm output head-major and rewrites it
// token-major so every token owns one contiguous N_HEAD*WPR word row.
// Reads are credit-limited so the return FIFO can never overflow.
module mhsa_connect_gather import mhsa_pkg::*; #(
    parameter int DATA_W     = mhsa_pkg::DATA_W,
    parameter int ADDR_W     = mhsa_pkg::ADDR_W,
    parameter int N_HEAD     = mhsa_pkg::N_HEAD,
    parameter int SEQ_LEN    = mhsa_pkg::SEQ_LEN,
    parameter int WPR        = mhsa_pkg::WPR,
    parameter int FIFO_DEPTH = mhsa_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_gnt
);

    localparam int L_TOTAL = N_HEAD * SEQ_LEN * WPR;
    localparam int IDX_W   = $clog2(L_TOTAL) + 1;
    localparam int ENT_W   = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W   = CNT_W + 1;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_inflight;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_dst_base;
    logic [ADDR_W-1:0] r_pend_addr;

    logic              w_rd_en;
    logic              w_rd_acc;
    logic              w_wr_en;
    logic              w_wr_acc;
    logic              w_last_rd;
    logic              w_drain_ok;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_cnt;
    logic [CRD_W-1:0]  w_credit;
    logic [ENT_W-1:0]  w_fifo_in;
    logic [ENT_W-1:0]  w_fifo_head;
    logic [ADDR_W-1:0] w_idx_ext;
    logic [ADDR_W-1:0] w_word;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_head_n;
    logic [ADDR_W-1:0] w_dst_addr;

    // Index decode: i = h*(SEQ_LEN*WPR) + r*WPR + w  ->  token-major slot
    assign w_idx_ext  = ADDR_W'(r_idx);
    assign w_word     = w_idx_ext % ADDR_W'(WPR);
    assign w_row      = (w_idx_ext / ADDR_W'(WPR)) % ADDR_W'(SEQ_LEN);
    assign w_head_n   = w_idx_ext / ADDR_W'(WPR * SEQ_LEN);
    assign w_dst_addr = r_dst_base + w_row * ADDR_W'(N_HEAD * WPR)
                      + w_head_n * ADDR_W'(WPR) + w_word;

    // Credit counts both buffered words and the one possibly on the return bus
    assign w_credit  = CRD_W'(w_fifo_cnt) + CRD_W'(r_inflight);
    assign w_rd_en   = (r_state == RUN) && (w_credit < CRD_W'(FIFO_DEPTH));
    assign w_rd_acc  = w_rd_en && rd_gnt;
    assign w_last_rd = (r_idx == IDX_W'(L_TOTAL - 1));

    assign w_wr_en  = !w_fifo_empty;
    assign w_wr_acc = w_wr_en && wr_gnt;

    // Finished once nothing is returning and the last buffered word leaves now
    assign w_drain_ok = !r_inflight &&
                        (w_fifo_empty || ((w_fifo_cnt == CNT_W'(1)) && w_wr_acc));

    assign w_fifo_in = {r_pend_addr, rd_data};

    mhsa_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (w_fifo_in),
        .i_pop   (w_wr_acc),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_cnt),
        .o_empty (w_fifo_empty)
    );

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = w_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = w_wr_en;
    // Head fields are masked while empty so idle outputs read as zero
    assign wr_addr = w_wr_en ? w_fifo_head[ENT_W-1:DATA_W] : '0;
    assign wr_data = w_wr_en ? w_fifo_head[DATA_W-1:0]     : '0;

    // Control FSM: start acceptance, read sequencing, drain and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_idx      <= '0;
            r_rd_addr  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_rd_acc;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_idx     <= '0;
                        r_rd_addr <= src_base;
                    end
                end
                RUN: begin
                    if (w_rd_acc) begin
                        r_idx     <= r_idx + IDX_W'(1);
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        if (w_last_rd) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_ok) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Address datapath registers: latched destination base and the slot of the read on the bus
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && start) begin
            r_dst_base <= dst_base;
        end
        if (w_rd_acc) begin
            r_pend_addr <= w_dst_addr;
        end
    end

endmodule

// File: tb/tb_mhsa_connect_gather.sv
// Directed bench for the head-concatenation mover with a memory responder.
module tb_mhsa_connect_gather;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_base;
    logic [31:0] dst_base;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic        wr_gnt;

    mhsa_connect_gather dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [63:0] tag;
    } vec_t;

    vec_t        vecs [5];
    logic [63:0] mem [4096];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    logic [31:0] cur_src, cur_dst, exp_rd_addr;
    logic [63:0] nxt_data;
    int nreads, nwrites, ndone, done_rel, busy_first, busy_last, n_block;
    int rd_mode   = 0;
    int hold_at   = -1;
    int hold_left = 0;
    int poke_at   = -1;

    logic        p_rd_stall, p_wr_stall;
    logic [31:0] p_rd_addr, p_wr_addr;
    logic [63:0] p_wr_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source word for linear index i: {h, r, w} byte tag
    function automatic logic [63:0] tag(input logic [31:0] i);
        tag = {40'd0, 8'(i / 128), 8'((i / 4) % 32), 8'(i % 4)};
    endfunction

    // One cycle: drive grants and return data at the falling edge, then observe
    task automatic step();
        int outst;
        @(negedge clk);
        cyc++;
        rd_data  = nxt_data;
        nxt_data = '0;
        if (hold_at >= 0 && (cyc - t0) == hold_at) hold_left = 20;
        if (poke_at >= 0 && (cyc - t0) == poke_at) begin
            start = 1'b1; src_base = 32'd100; dst_base = 32'd5000;
        end else if (poke_at >= 0 && (cyc - t0) == poke_at + 1) begin
            start = 1'b0;
        end
        rd_gnt = (rd_mode != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
        if (hold_left > 0) begin
            wr_gnt = 1'b0;
            hold_left--;
        end else begin
            wr_gnt = 1'b1;
        end
        if (!rst_n) begin
            p_rd_stall = 1'b0;
            p_wr_stall = 1'b0;
            return;
        end
        if (p_rd_stall) begin
            chk("rd_hold_en", rd_en, 1);
            chk("rd_hold_addr", rd_addr, p_rd_addr);
        end
        if (p_wr_stall) begin
            chk("wr_hold_en", wr_en, 1);
            chk("wr_hold_addr", wr_addr, p_wr_addr);
            chk("wr_hold_data", wr_data, p_wr_data);
        end
        outst = nreads - nwrites;
        chk("credit_max", outst <= 4, 1);
        if (outst >= 4) begin
            chk("credit_block", rd_en, 0);
            n_block++;
        end
        if (rd_en && rd_gnt) begin
            chk("rd_seq", rd_addr, exp_rd_addr);
            nxt_data    = tag(rd_addr - cur_src);
            exp_rd_addr = exp_rd_addr + 1;
            nreads++;
        end
        if (wr_en && wr_gnt) begin
            chk("wr_range", (wr_addr - cur_dst) < 32'd512, 1);
            mem[wr_addr[11:0]] = wr_data;
            nwrites++;
        end
        if (busy) begin
            if (busy_first < 0) busy_first = cyc - t0;
            busy_last = cyc - t0;
        end
        if (done) begin
            ndone++;
            done_rel = cyc - t0;
        end
        p_rd_stall = rd_en && !rd_gnt;
        p_rd_addr  = rd_addr;
        p_wr_stall = wr_en && !wr_gnt;
        p_wr_addr  = wr_addr;
        p_wr_data  = wr_data;
    endtask

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input bit keep);
        for (int k = 0; k < 4096; k++) mem[k] = '1;
        cur_src = src; cur_dst = dst; exp_rd_addr = src;
        nreads = 0; nwrites = 0; ndone = 0; done_rel = -1;
        busy_first = -1; busy_last = -1; n_block = 0;
        src_base = src; dst_base = dst; start = 1'b1;
        t0 = cyc;
        step();
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (ndone == 0 && n < budget) begin
            step();
            n++;
        end
        chk("done_timeout", ndone > 0, 1);
    endtask

    // Full destination image against the token-major placement formula
    task automatic check_image(input string name);
        logic [31:0] d;
        int errs = 0;
        logic [63:0] first_got = '0, first_exp = '0;
        for (int i = 0; i < 512; i++) begin
            d = cur_dst + ((i / 4) % 32) * 16 + (i / 128) * 4 + (i % 4);
            if (mem[d[11:0]] !== tag(i)) begin
                if (errs == 0) begin first_got = mem[d[11:0]]; first_exp = tag(i); end
                errs++;
            end
        end
        chk(name, first_got, first_exp);
        chk({name, "_errs"}, errs, 0);
    endtask

    initial begin
        vecs[0] = '{idx: 0,   addr: 32'd3072, tag: 64'h0000_0000};
        vecs[1] = '{idx: 1,   addr: 32'd3073, tag: 64'h0000_0001};
        vecs[2] = '{idx: 4,   addr: 32'd3088, tag: 64'h0000_0100};
        vecs[3] = '{idx: 128, addr: 32'd3076, tag: 64'h0001_0000};
        vecs[4] = '{idx: 511, addr: 32'd3583, tag: 64'h0003_1F03};

        rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0;
        rd_gnt = 1'b1; wr_gnt = 1'b1; rd_data = '0; nxt_data = '0;
        p_rd_stall = 1'b0; p_wr_stall = 1'b0;
        p_rd_addr = '0; p_wr_addr = '0; p_wr_data = '0;
        cur_src = '0; cur_dst = '0; exp_rd_addr = '0;
        nreads = 0; nwrites = 0; ndone = 0; done_rel = -1;
        busy_first = -1; busy_last = -1; n_block = 0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Full transfer, grants always high
        start_xfer(32'd2560, 32'd3072, 1'b0);
        chk("rd_first", rd_addr, 32'd2560);
        wait_done(2000);
        chk("done_cycle", done_rel, 515);
        chk("busy_first", busy_first, 1);
        chk("busy_last", busy_last, 514);
        chk("n_reads", nreads, 512);
        chk("n_writes", nwrites, 512);
        for (int v = 0; v < 5; v++) begin
            chk($sformatf("vec_idx%0d", vecs[v].idx), mem[vecs[v].addr[11:0]], vecs[v].tag);
        end
        check_image("img_full");
        repeat (5) step();
        chk("done_once", ndone, 1);

        // Random read grants at ~30%
        rd_mode = 1;
        start_xfer(32'd2560, 32'd3072, 1'b0);
        wait_done(10000);
        rd_mode = 0;
        chk("rnd_reads", nreads, 512);
        chk("rnd_writes", nwrites, 512);
        check_image("img_rnd");
        repeat (5) step();

        // Write backpressure for 20 cycles mid-run
        hold_at = 100;
        start_xfer(32'd2560, 32'd3072, 1'b0);
        wait_done(3000);
        hold_at = -1;
        chk("bp_blocked_seen", n_block > 0, 1);
        chk("bp_writes", nwrites, 512);
        check_image("img_bp");
        repeat (5) step();

        // Start held high after done must not retrigger
        start_xfer(32'd2560, 32'd3072, 1'b1);
        wait_done(2000);
        repeat (20) step();
        chk("held_done_cnt", ndone, 1);
        chk("held_reads", nreads, 512);
        chk("held_busy_last", busy_last, 514);
        start = 1'b0;
        repeat (2) step();
        start_xfer(32'd2560, 32'd0, 1'b0);
        wait_done(2000);
        chk("dst0_writes", nwrites, 512);
        chk("dst0_word0", mem[0], 64'h0);
        chk("dst0_word511", mem[511], 64'h0003_1F03);
        check_image("img_dst0");
        repeat (5) step();

        // Reset in the middle of a transfer
        start_xfer(32'd2560, 32'd3072, 1'b0);
        while ((cyc - t0) < 100) step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        repeat (4) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("mid_rst_no_done", ndone, 0);
        start_xfer(32'd2560, 32'd3072, 1'b0);
        wait_done(2000);
        chk("post_rst_writes", nwrites, 512);
        chk("post_rst_done", done_rel, 515);
        check_image("img_post_rst");
        repeat (5) step();

        // Start re-pulsed while busy with different bases
        poke_at = 50;
        start_xfer(32'd2560, 32'd3072, 1'b0);
        wait_done(2000);
        repeat (10) step();
        poke_at = -1;
        chk("poke_done_cnt", ndone, 1);
        chk("poke_reads", nreads, 512);
        check_image("img_poke");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mhsa_connect_gather.md
Name: mhsa_connect_gather

Overview:
Head-concatenation ("connect") stage. It sits directly downstream of the attention-matmul (attmm) stage. It reads the per-head attmm output, stored head-major in one SRAM bank, and writes it token-major into another bank. The result is one 32 x 128 int8 row per token, which is what the output projection and the final connect checks consume. It is a pipelined read/permute/write mover with port-grant backpressure.

Parameters:
DATA_W, 64, SRAM word width in bits.
ADDR_W, 32, SRAM address width.
N_HEAD, 4, number of attention heads.
SEQ_LEN, 32, tokens per sequence.
WPR, 4, 64-bit words per head row (32 int8 / 8).
FIFO_DEPTH, 4, return-data buffer depth (power of 2, >= 2).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  level request; accepted only in IDLE
src_base  in  ADDR_W  attmm output base word address; sampled at start acceptance
dst_base  in  ADDR_W  connect output base word address; sampled at start acceptance
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the final write is accepted
rd_en  out  1  read request to source bank
rd_addr  out  ADDR_W  source word address
rd_gnt  in  1  read accepted this cycle (rd_en && rd_gnt)
rd_data  in  DATA_W  valid exactly 1 cycle after an accepted read
wr_en  out  1  write request to destination bank
wr_addr  out  ADDR_W  destination word address
wr_data  out  DATA_W  write data
wr_gnt  in  1  write accepted this cycle (wr_en && wr_gnt)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). Reset is sampled on the clk edge only.
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0. The FIFO is empty, all counters are 0, and the FSM is in IDLE.
- Transfer size: TOTAL = N_HEAD*SEQ_LEN*WPR = 512 words.
- Read index i runs 0..TOTAL-1 in order, giving rd_addr = src_base + i.
- Index decode: w = i mod WPR; r = (i / WPR) mod SEQ_LEN; h = i / (WPR*SEQ_LEN).
- Destination address: dst_base + r*(N_HEAD*WPR) + h*WPR + w. Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W.
- FSM states:
  - IDLE: on start=1, latch the bases, clear counters, set busy, go to RUN.
  - RUN: issue reads. After the read for index TOTAL-1 is accepted, go to DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty, with the last write accepted. Then pulse done, drop busy, go to DONE.
  - DONE: stay while start=1; go to IDLE when start=0. A held level start therefore never retriggers.
- Read issue:
  - rd_en=1 in RUN when credit = fifo_count + inflight < FIFO_DEPTH.
  - rd_addr and the index advance only when rd_gnt=1. While rd_en is high and not granted, rd_addr holds stable.
- Return path:
  - Each accepted read sets inflight for 1 cycle. The next cycle, rd_data and its precomputed dst address are pushed into the FIFO.
  - The FIFO can never overflow by construction of the credit rule.
- Write path:
  - wr_en = FIFO non-empty. wr_addr and wr_data come from the FIFO head.
  - The FIFO pops only on wr_gnt. While not granted, wr_addr and wr_data hold stable.
  - A push and a pop in the same cycle leave the count unchanged.
- Throughput and latency with rd_gnt=wr_gnt=1 throughout:
  - Start accepted at edge 0; rd_en is high in cycles 1..512.
  - Writes occur in cycles 3..514.
  - done pulses in cycle 515.
- start while busy is ignored. base changes after acceptance have no effect.
- rst_n=0 mid-transfer: all state returns to reset values on the next edge. In-flight data is discarded and no done is produced.

Decomposition:
- mhsa_pkg holds:
  - the WIDTH, N_HEAD, SEQ_LEN and WPR constants;
  - the TOTAL localparam;
  - the bank base constants (ATTMM_OUTPUT_BASE=2560, CONNECT_OUTPUT_BASE=3072);
  - the FSM state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: mhsa_sync_fifo, a parameterised-width/depth synchronous FIFO with push/pop/count. Each entry is {dst_addr, data}.

Test Plan:
- Full transfer, grants tied to 1, src_base=2560, dst_base=3072, source word = {h,r,w} tag -> each destination holds the expected tag:
  - idx0 -> 3072; idx1 -> 3073; idx4 -> 3088; idx128 -> 3076; idx511 -> 3583;
  - exactly 512 writes; done in cycle 515; busy high for cycles 1..514.
- rd_gnt random at 30% -> rd_addr is stable while ungranted, there are no duplicate or skipped reads, and the final memory image is identical to the previous case.
- wr_gnt=0 for 20 cycles mid-run -> rd_en drops once credit reaches 4, the FIFO never overflows, wr_addr and wr_data hold, and the transfer completes correctly after release.
- start held high after done -> no second transfer; drop start, raise it again -> a second full transfer with new dst_base=0 lands at 0..511 permuted.
- rst_n=0 asserted at cycle 100 -> next cycle all outputs are 0; no done; a fresh start afterwards runs a clean full transfer.
- start pulsed again while busy with different bases -> ignored; the original bases are used throughout.
